dwt_coeff_streamer: RTL and testbench

Downstream consumer of the pipelined Haar DWT core. On each completed transform (rising edge of the core's `done`), it snapshots the parallel `cA`/`cD` coefficient vectors. It then streams them out one 16-bit word per beat over a valid/ready handshake: all approximation coefficients first, then all detail coefficients. Detail coefficients can optionally be hard-thresholded for denoising. The snapshot frees the core to start the next frame while the current one drains.

---
 rtl/dwt_pkg.sv | 17 +
 rtl/dwt_coeff_thresh.sv | 27 ++
 rtl/dwt_coeff_streamer.sv | 147 ++++++++++++++
 tb/tb_dwt_coeff_streamer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dwt_pkg.sv
// dwt_pkg: definitions shared by the Haar DWT coefficient streamer.
//   COEF_W      - default coefficient width (Q8.8 two's complement)
//   dwt_state_t - streamer FSM states
//   coef_t      - one coefficient word
package dwt_pkg;

   localparam int unsigned COEF_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM_A,
      ST_STREAM_D
   } dwt_state_t;

   typedef logic [COEF_W-1:0] coef_t;

endpackage

// File: rtl/dwt_coeff_thresh.sv
// dwt_coeff_thresh: combinational hard threshold for one detail coefficient.
// Ports:
//   coef   - W-bit two's complement coefficient
//   thresh - W-bit unsigned magnitude threshold
//   result - coef, or 0 when |coef| < thresh
// The magnitude is formed in W+1 bits so the most negative value keeps its
// full magnitude; thresh = 0 therefore never zeroes a word.
module dwt_coeff_thresh
   import dwt_pkg::*;
#(
   parameter int unsigned W = COEF_W
) (
   input  logic [W-1:0] coef,
   input  logic [W-1:0] thresh,
   output logic [W-1:0] result
);

   logic [W:0] ext;
   logic [W:0] mag;

   always_comb begin
      ext    = {coef[W-1], coef};
      mag    = coef[W-1] ? -ext : ext;
      result = (mag < {1'b0, thresh}) ? '0 : coef;
   end

endmodule

// File: rtl/dwt_coeff_streamer.sv
// dwt_coeff_streamer: snapshots the cA/cD vectors of the Haar DWT core on each
// rising edge of done_in and streams them out, one word per valid/ready beat,
// all cA words first then all cD words.
// Optional feature macro: DWT_COEFF_THRESH_EN (hard-threshold cD words by thresh).
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   done_in      - level done from DWT controller, rising edge = new frame
//   cA_in, cD_in - packed coefficient vectors, word k at [k*W +: W]
//   thresh       - unsigned magnitude threshold (macro builds only)
//   m_valid, m_ready, m_data, m_is_detail, m_idx, m_last - output stream
//   busy         - frame held / streaming
//   overflow     - sticky, a frame was dropped while busy
module dwt_coeff_streamer
   import dwt_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = COEF_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   done_in,
   input  logic [W*(N/2)-1:0]     cA_in,
   input  logic [W*(N/2)-1:0]     cD_in,
   input  logic [W-1:0]           thresh,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [W-1:0]           m_data,
   output logic                   m_is_detail,
   output logic [$clog2(N/2)-1:0] m_idx,
   output logic                   m_last,
   output logic                   busy,
   output logic                   overflow
);

   localparam int unsigned H  = N / 2;
   localparam int unsigned IW = $clog2(H);

   typedef logic [W-1:0] word_t;

   dwt_state_t      state;
   logic            done_q;
   logic            busy_r;
   word_t           snap_a [H];
   word_t           snap_d [H];

   logic            rise;
   logic            hs;
   logic            accept;
   int unsigned     nxt;
   logic [IW-1:0]   a_sel;
   logic [IW-1:0]   d_sel;
   word_t           a_next;
   word_t           d_raw;
   word_t           d_next;

   // Output registers hold the word being presented, so the next word is
   // looked up ahead of the handshake that advances to it.
   always_comb begin
      rise   = done_in & ~done_q;
      hs     = busy_r & m_ready;
      accept = rise & ((state == ST_IDLE) | (hs & m_last));
      nxt    = 32'(m_idx) + 1;
      a_sel  = (nxt >= H) ? '0 : IW'(nxt);
      d_sel  = (state == ST_STREAM_A) ? '0 : a_sel;
      a_next = snap_a[a_sel];
      d_raw  = snap_d[d_sel];
   end

`ifdef DWT_COEFF_THRESH_EN
   dwt_coeff_thresh #(.W(W)) u_thresh (
      .coef   (d_raw),
      .thresh (thresh),
      .result (d_next)
   );
`else
   logic unused_thresh;
   assign unused_thresh = ^thresh;
   assign d_next        = d_raw;
`endif

   assign m_valid = busy_r;
   assign busy    = busy_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         done_q      <= 1'b0;
         busy_r      <= 1'b0;
         m_data      <= '0;
         m_is_detail <= 1'b0;
         m_idx       <= '0;
         m_last      <= 1'b0;
         overflow    <= 1'b0;
         for (int unsigned k = 0; k < H; k++) begin
            snap_a[k] <= '0;
            snap_d[k] <= '0;
         end
      end else begin
         done_q <= done_in;
         if (rise && !accept) overflow <= 1'b1;

         if (accept) begin
            // Also taken on the m_last handshake: restart with no idle bubble.
            for (int unsigned k = 0; k < H; k++) begin
               snap_a[k] <= cA_in[k*W +: W];
               snap_d[k] <= cD_in[k*W +: W];
            end
            state       <= ST_STREAM_A;
            busy_r      <= 1'b1;
            m_data      <= cA_in[W-1:0];
            m_is_detail <= 1'b0;
            m_idx       <= '0;
            m_last      <= 1'b0;
         end else if (hs) begin
            case (state)
               ST_STREAM_A: begin
                  if (m_idx == IW'(H-1)) begin
                     state       <= ST_STREAM_D;
                     m_idx       <= '0;
                     m_is_detail <= 1'b1;
                     m_data      <= d_next;
                  end else begin
                     m_idx  <= a_sel;
                     m_data <= a_next;
                  end
               end
               ST_STREAM_D: begin
                  if (m_last) begin
                     state       <= ST_IDLE;
                     busy_r      <= 1'b0;
                     m_last      <= 1'b0;
                     m_is_detail <= 1'b0;
                     m_idx       <= '0;
                     m_data      <= '0;
                  end else begin
                     m_idx  <= a_sel;
                     m_data <= d_next;
                     m_last <= (a_sel == IW'(H-1));
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dwt_coeff_streamer.sv
// tb_dwt_coeff_streamer: scoreboard bench for dwt_coeff_streamer (N=8, W=16).
// Expected beats are queued when a frame is launched; a negedge monitor
// compares every presented beat against the queue head and pops on handshake.
module tb_dwt_coeff_streamer;

   localparam int unsigned N = 8;
   localparam int unsigned W = 16;

   typedef struct packed {
      logic [15:0] data;
      logic        det;
      logic [1:0]  idx;
      logic        last;
   } beat_t;

   logic          clk;
   logic          rst_n;
   logic          done_in;
   logic [63:0]   cA_in;
   logic [63:0]   cD_in;
   logic [15:0]   thresh;
   logic          m_valid;
   logic          m_ready;
   logic [15:0]   m_data;
   logic          m_is_detail;
   logic [1:0]    m_idx;
   logic          m_last;
   logic          busy;
   logic          overflow;

   int            checks;
   int            errors;
   beat_t         exp_q [$];

   localparam logic [63:0] A0 = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
   localparam logic [63:0] D0 = {16'hFF00, 16'h0080, 16'hFFF0, 16'h0010};
   localparam logic [63:0] A1 = {16'h0444, 16'h0333, 16'h0222, 16'h0111};
   localparam logic [63:0] D1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
   localparam logic [63:0] D2 = {16'h0020, 16'hFFE1, 16'h001F, 16'h8000};

   dwt_coeff_streamer #(.N(N), .W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .done_in     (done_in),
      .cA_in       (cA_in),
      .cD_in       (cD_in),
      .thresh      (thresh),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_is_detail (m_is_detail),
      .m_idx       (m_idx),
      .m_last      (m_last),
      .busy        (busy),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every presented beat must equal the queue head (this also
   // covers stability during stalls); the head is retired on handshake.
   always @(negedge clk) begin
      beat_t got;
      if (rst_n && m_valid) begin
         checks++;
         got = '{data: m_data, det: m_is_detail, idx: m_idx, last: m_last};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got=%h required=none", got);
         end else begin
            if (got !== exp_q[0]) begin
               errors++;
               $display("FAIL beat got=%h required=%h", got, exp_q[0]);
            end
            if (m_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input logic [63:0] a, input logic [63:0] d,
                             input logic [63:0] d_exp);
      cA_in = a;
      cD_in = d;
      for (int k = 0; k < 4; k++)
         exp_q.push_back('{data: a[k*16 +: 16], det: 1'b0, idx: 2'(k), last: 1'b0});
      for (int k = 0; k < 4; k++)
         exp_q.push_back('{data: d_exp[k*16 +: 16], det: 1'b1, idx: 2'(k), last: (k == 3)});
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (exp_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL drain_timeout pending=%0d busy=%b required=0/0", exp_q.size(), busy);
         exp_q.delete();
      end
   endtask

   task automatic check_zero_outputs(input string name);
      logic [22:0] got;
      got = {m_valid, m_data, m_is_detail, m_idx, m_last, busy, overflow};
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL %s outputs=%h required=0", name, got);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      check_zero_outputs("reset_held");
      rst_n = 1'b1;
      tick();
      tick();
      check_zero_outputs("reset_released");
   endtask

   task automatic test_basic();
      int cycles;
      m_ready = 1'b1;
      load_frame(A0, D0, D0);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h0100) begin
         errors++;
         $display("FAIL basic_latency valid=%b data=%h required=1/0100", m_valid, m_data);
      end
      cycles = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         cycles++;
         if (!busy) break;
      end
      checks++;
      if (cycles != 8) begin
         errors++;
         $display("FAIL basic_drain_cycles got=%0d required=8", cycles);
      end
      wait_drain();
   endtask

   task automatic test_backpressure();
      logic [3:0] pat;
      bit         ok;
      pat = 4'b1001;
      ok  = 1'b0;
      m_ready = 1'b1;
      load_frame(A0, D0, D0);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      for (int i = 0; i < 200; i++) begin
         m_ready = pat[i % 4];
         tick();
         if (exp_q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      m_ready = 1'b1;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL backpressure_timeout pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_input_change();
      m_ready = 1'b1;
      load_frame(A0, D0, D0);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      tick();
      cA_in = {4{16'hAAAA}};
      cD_in = {4{16'h5555}};
      wait_drain();
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b1;
      load_frame(A0, D0, D0);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      repeat (7) tick();
      load_frame(A1, D1, D1);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      checks++;
      if (busy !== 1'b1 || m_valid !== 1'b1 || m_data !== 16'h0111 || m_is_detail !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back_start busy=%b valid=%b data=%h det=%b required=1/1/0111/0",
                  busy, m_valid, m_data, m_is_detail);
      end
      wait_drain();
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back_overflow got=%b required=0", overflow);
      end
   endtask

   task automatic test_overflow();
      m_ready = 1'b1;
      load_frame(A0, D0, D0);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      tick();
      tick();
      checks++;
      if (m_idx !== 2'd2 || m_is_detail !== 1'b0) begin
         errors++;
         $display("FAIL overflow_beat3 idx=%0d det=%b required=2/0", m_idx, m_is_detail);
      end
      cA_in = {4{16'h1234}};
      cD_in = {4{16'h4321}};
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set got=%b required=1", overflow);
      end
      wait_drain();
      repeat (3) tick();
      checks++;
      if (overflow !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL overflow_sticky ovf=%b busy=%b required=1/0", overflow, busy);
      end
   endtask

   task automatic test_thresh();
      logic [63:0] exp1;
      logic [63:0] exp2;
`ifdef DWT_COEFF_THRESH_EN
      exp1 = {16'hFF00, 16'h0080, 16'h0000, 16'h0000};
      exp2 = {16'h0020, 16'h0000, 16'h0000, 16'h8000};
`else
      exp1 = D0;
      exp2 = D2;
`endif
      m_ready = 1'b1;
      thresh  = 16'h0020;
      load_frame(A0, D0, exp1);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      wait_drain();
      load_frame(A1, D2, exp2);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      wait_drain();
      thresh = 16'h0000;
   endtask

   task automatic test_async_reset();
      m_ready = 1'b1;
      load_frame(A0, D0, D0);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      repeat (3) tick();
      checks++;
      if (m_idx !== 2'd3 || m_data !== 16'h0400) begin
         errors++;
         $display("FAIL reset_beat4 idx=%0d data=%h required=3/0400", m_idx, m_data);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      load_frame(A0, D0, D0);
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'h0100 || m_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset_restart valid=%b data=%h idx=%0d required=1/0100/0",
                  m_valid, m_data, m_idx);
      end
      wait_drain();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      done_in = 1'b0;
      cA_in   = '0;
      cD_in   = '0;
      thresh  = '0;
      m_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_input_change();
      test_back_to_back();
      test_overflow();
      test_thresh();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
